// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and types for the pipe_chain slice
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int STAGES_DEF = 4;
  localparam int STAGES_MAX = 8;

  localparam int CNT_W = 16;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_SAT = 16'hFFFF;

endpackage

// File: rtl/pipe_chain_if.sv
// rtl/pipe_chain_if.sv - upstream, control and observation signals of pipe_chain
interface pipe_chain_if #(
  parameter int DATA_W = pipe_pkg::DATA_W_DEF,
  parameter int STAGES = pipe_pkg::STAGES_DEF
);
  import pipe_pkg::*;

  logic              in_valid_i;
  logic [DATA_W-1:0] in_data_i;
  logic              in_ready_o;
  logic [STAGES-1:0] stall_i;
  logic [STAGES-1:0] flush_i;
  logic [STAGES-1:0] stage_valid_o;
  logic              out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  cnt_t              bubble_cnt_o;

  modport master (
    output in_valid_i, in_data_i, stall_i, flush_i,
    input  in_ready_o, stage_valid_o, out_valid_o, out_data_o, bubble_cnt_o
  );

  modport slave (
    input  in_valid_i, in_data_i, stall_i, flush_i,
    output in_ready_o, stage_valid_o, out_valid_o, out_data_o, bubble_cnt_o
  );

endinterface

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid+data pipeline register with hold, bubble and flush
module pipe_stage import pipe_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              bubble,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // Data follows the previous stage whenever not held; valid is killed by flush first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (!hold) begin
        data <= in_data;
      end
      if (flush) begin
        valid <= 1'b0;
      end else if (!hold) begin
        valid <= bubble ? 1'b0 : in_valid;
      end
    end
  end

endmodule

// File: rtl/pipe_chain.sv
// rtl/pipe_chain.sv - lockstep stallable pipeline with per-stage flush and bubble counter
module pipe_chain import pipe_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input logic         clk_i,
  input logic         rst_i,
  pipe_chain_if.slave bus
);

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] bubble;
  logic [STAGES-1:0] valid_q;
  logic [DATA_W-1:0] data_q [STAGES];
  cnt_t              bubble_cnt;

  // A stage holds if it or any later stage stalls (suffix OR of stall_i)
  always_comb begin
    hold = '0;
    for (int k = 0; k < STAGES; k++) begin
      hold[k] = |(bus.stall_i >> k);
    end
  end

  // A stage gets a bubble when it advances while its predecessor is held
  always_comb begin
    bubble = '0;
    for (int k = 1; k < STAGES; k++) begin
      bubble[k] = hold[k-1] & ~hold[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic              prev_valid;
    logic [DATA_W-1:0] prev_data;

    if (k == 0) begin : g_head
      assign prev_valid = bus.in_valid_i;
      assign prev_data  = bus.in_data_i;
    end else begin : g_body
      assign prev_valid = valid_q[k-1];
      assign prev_data  = data_q[k-1];
    end

    pipe_stage #(.DATA_W(DATA_W)) u_stage (
      .clk      (clk_i),
      .rst      (rst_i),
      .hold     (hold[k]),
      .bubble   (bubble[k]),
      .flush    (bus.flush_i[k]),
      .in_valid (prev_valid),
      .in_data  (prev_data),
      .valid    (valid_q[k]),
      .data     (data_q[k])
    );
  end

  // Count cycles in which any stage takes a bubble, sticking at all-ones
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_cnt <= '0;
    end else if ((|bubble) && (bubble_cnt != CNT_SAT)) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  assign bus.in_ready_o    = ~hold[0];
  assign bus.stage_valid_o = valid_q;
  assign bus.out_valid_o   = valid_q[STAGES-1];
  assign bus.out_data_o    = data_q[STAGES-1];
  assign bus.bubble_cnt_o  = bubble_cnt;

endmodule

// File: tb/tb_pipe_chain.sv
// tb/tb_pipe_chain.sv - scoreboard bench for pipe_chain (STAGES=4 and STAGES=1)
module tb_pipe_chain;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_chain_if #(.DATA_W(DW), .STAGES(NS)) bus ();
  pipe_chain_if #(.DATA_W(DW), .STAGES(1))  bus1 ();

  pipe_chain #(.DATA_W(DW), .STAGES(NS)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));
  pipe_chain #(.DATA_W(DW), .STAGES(1))  dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1.slave));

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] exp_d;
  logic [DW-1:0] nxt;

  task automatic idle_inputs();
    bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.stall_i = '0; bus.flush_i = '0;
    bus1.in_valid_i = 1'b0; bus1.in_data_i = '0; bus1.stall_i = '0; bus1.flush_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    vectors++; if (bus.stage_valid_o !== 4'b0000) begin miscompares++; $display("FAIL reset_stage_valid: got %b required 0000", bus.stage_valid_o); end
    vectors++; if (bus.out_data_o !== 32'h0) begin miscompares++; $display("FAIL reset_out_data: got %h required 0", bus.out_data_o); end
    vectors++; if (bus.bubble_cnt_o !== 16'h0) begin miscompares++; $display("FAIL reset_bubble_cnt: got %h required 0", bus.bubble_cnt_o); end
    vectors++; if (bus.in_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready_o); end
    bus.stall_i = 4'b1000; bus1.stall_i = 1'b1;
    #1;
    vectors++; if (bus.in_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready_stalled: got %b required 0", bus.in_ready_o); end
    vectors++; if (bus1.in_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset1_in_ready_stalled: got %b required 0", bus1.in_ready_o); end
    vectors++; if (bus1.out_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset1_out_valid: got %b required 0", bus1.out_valid_o); end
    idle_inputs();
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.in_valid_i = (i < 4);
      bus.in_data_i  = 32'h11 + i;
      #1;
      if (bus.in_valid_i && bus.in_ready_o) sb.push_back(bus.in_data_i);
      vectors++; if (bus.out_valid_o !== (i >= 4 && i < 8)) begin miscompares++; $display("FAIL stream_latency_%0d: got %b required %b", i, bus.out_valid_o, (i >= 4 && i < 8)); end
      if (bus.out_valid_o && !bus.stall_i[NS-1]) begin
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("FAIL stream_extra: got %h required none", bus.out_data_o); end
        else begin exp_d = sb.pop_front(); if (bus.out_data_o !== exp_d) begin miscompares++; $display("FAIL stream_data: got %h required %h", bus.out_data_o, exp_d); end end
      end
      @(posedge clk); #1;
    end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL stream_lost: got %0d left required 0", sb.size()); end
    vectors++; if (bus.bubble_cnt_o !== 16'h0) begin miscompares++; $display("FAIL stream_bubble_cnt: got %h required 0", bus.bubble_cnt_o); end
  endtask

  task automatic test_stall();
    do_reset();
    nxt = 32'h20;
    for (int j = 0; j < 16; j++) begin
      bus.in_valid_i = (nxt < 32'h26);
      bus.in_data_i  = nxt;
      bus.stall_i    = (j == 4 || j == 5) ? 4'b0100 : 4'b0000;
      #1;
      if (j == 4 || j == 5) begin
        vectors++; if (bus.in_ready_o !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready: got %b required 0", bus.in_ready_o); end
      end
      if (bus.in_valid_i && bus.in_ready_o) begin sb.push_back(nxt); nxt = nxt + 1; end
      if (bus.out_valid_o && !bus.stall_i[NS-1]) begin
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("FAIL stall_dup: got %h required none", bus.out_data_o); end
        else begin exp_d = sb.pop_front(); if (bus.out_data_o !== exp_d) begin miscompares++; $display("FAIL stall_data: got %h required %h", bus.out_data_o, exp_d); end end
      end
      @(posedge clk); #1;
      if (j == 4 || j == 5) begin
        vectors++; if (bus.stage_valid_o !== 4'b0111) begin miscompares++; $display("FAIL stall_stage_valid: got %b required 0111", bus.stage_valid_o); end
        vectors++; if (bus.bubble_cnt_o !== 16'(j - 3)) begin miscompares++; $display("FAIL stall_bubble_step: got %h required %h", bus.bubble_cnt_o, 16'(j - 3)); end
      end
    end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL stall_lost: got %0d left required 0", sb.size()); end
    vectors++; if (bus.bubble_cnt_o !== 16'h2) begin miscompares++; $display("FAIL stall_bubble_cnt: got %h required 2", bus.bubble_cnt_o); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid_i = 1'b1; bus.in_data_i = 32'h30 + i;
      #1;
      if (bus.in_ready_o) sb.push_back(bus.in_data_i);
      @(posedge clk); #1;
    end
    bus.in_valid_i = 1'b0; bus.flush_i = 4'b0011; bus.stall_i = 4'b0010;
    #1;
    vectors++; exp_d = sb.pop_front();
    if (bus.out_data_o !== exp_d) begin miscompares++; $display("FAIL flush_consume: got %h required %h", bus.out_data_o, exp_d); end
    @(posedge clk); #1;
    void'(sb.pop_back()); void'(sb.pop_back());
    vectors++; if (bus.stage_valid_o[1:0] !== 2'b00) begin miscompares++; $display("FAIL flush_low_stages: got %b required 00", bus.stage_valid_o[1:0]); end
    vectors++; if (bus.stage_valid_o !== 4'b1000) begin miscompares++; $display("FAIL flush_stage_valid: got %b required 1000", bus.stage_valid_o); end
    vectors++; if (bus.out_data_o !== 32'h31) begin miscompares++; $display("FAIL flush_out_data: got %h required 31", bus.out_data_o); end
    vectors++; if (bus.bubble_cnt_o !== 16'h1) begin miscompares++; $display("FAIL flush_bubble_cnt: got %h required 1", bus.bubble_cnt_o); end
    bus.flush_i = '0; bus.stall_i = '0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid_i = (i < 4);
      bus.in_data_i  = 32'h40 + i;
      bus.flush_i    = (i == 4) ? 4'b0101 : 4'b0000;
      #1;
      if (bus.in_valid_i && bus.in_ready_o) sb.push_back(bus.in_data_i);
      if (bus.out_valid_o && !bus.stall_i[NS-1]) begin
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("FAIL flush_extra: got %h required none", bus.out_data_o); end
        else begin exp_d = sb.pop_front(); if (bus.out_data_o !== exp_d) begin miscompares++; $display("FAIL flush_data: got %h required %h", bus.out_data_o, exp_d); end end
      end
      @(posedge clk); #1;
    end
    sb.delete(1);
    vectors++; if (bus.stage_valid_o !== 4'b1010) begin miscompares++; $display("FAIL flush_split: got %b required 1010", bus.stage_valid_o); end
    bus.flush_i = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.out_valid_o && !bus.stall_i[NS-1]) begin
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("FAIL flush_drain_extra: got %h required none", bus.out_data_o); end
        else begin exp_d = sb.pop_front(); if (bus.out_data_o !== exp_d) begin miscompares++; $display("FAIL flush_drain_data: got %h required %h", bus.out_data_o, exp_d); end end
      end
      @(posedge clk); #1;
    end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL flush_lost: got %0d left required 0", sb.size()); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    bus.stall_i = 4'b0100;
    @(posedge clk); #1;
    bus.stall_i = '0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid_i = 1'b1; bus.in_data_i = 32'h50 + i;
      #1;
      if (bus.in_ready_o) sb.push_back(bus.in_data_i);
      @(posedge clk); #1;
    end
    bus.in_valid_i = 1'b0;
    vectors++; if (bus.out_data_o !== sb[0]) begin miscompares++; $display("FAIL mid_pre_data: got %h required %h", bus.out_data_o, sb[0]); end
    vectors++; if (bus.bubble_cnt_o !== 16'h1) begin miscompares++; $display("FAIL mid_pre_bubble: got %h required 1", bus.bubble_cnt_o); end
    #3;
    rst = 1'b1;
    bus.stall_i = 4'b0010;
    #1;
    vectors++; if (bus.stage_valid_o !== 4'b0000) begin miscompares++; $display("FAIL mid_stage_valid: got %b required 0000", bus.stage_valid_o); end
    vectors++; if (bus.out_data_o !== 32'h0) begin miscompares++; $display("FAIL mid_out_data: got %h required 0", bus.out_data_o); end
    vectors++; if (bus.bubble_cnt_o !== 16'h0) begin miscompares++; $display("FAIL mid_bubble_cnt: got %h required 0", bus.bubble_cnt_o); end
    vectors++; if (bus.in_ready_o !== 1'b0) begin miscompares++; $display("FAIL mid_in_ready: got %b required 0", bus.in_ready_o); end
    sb.delete();
  endtask

  task automatic test_saturation();
    do_reset();
    bus.stall_i = 4'b0001;
    repeat (65534) @(posedge clk);
    #1;
    vectors++; if (bus.bubble_cnt_o !== 16'hFFFE) begin miscompares++; $display("FAIL sat_pre: got %h required fffe", bus.bubble_cnt_o); end
    @(posedge clk); #1;
    vectors++; if (bus.bubble_cnt_o !== 16'hFFFF) begin miscompares++; $display("FAIL sat_reach: got %h required ffff", bus.bubble_cnt_o); end
    repeat (4465) @(posedge clk);
    #1;
    vectors++; if (bus.bubble_cnt_o !== 16'hFFFF) begin miscompares++; $display("FAIL sat_wrap: got %h required ffff", bus.bubble_cnt_o); end
    bus.stall_i = '0;
  endtask

  task automatic test_single_stage();
    logic st [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    nxt = 32'h60;
    for (int c = 0; c < 5; c++) begin
      bus1.in_valid_i = (nxt < 32'h62);
      bus1.in_data_i  = nxt;
      bus1.stall_i    = st[c];
      #1;
      vectors++; if (bus1.in_ready_o !== ~st[c]) begin miscompares++; $display("FAIL single_in_ready: got %b required %b", bus1.in_ready_o, ~st[c]); end
      if (bus1.in_valid_i && bus1.in_ready_o) begin sb.push_back(nxt); nxt = nxt + 1; end
      if (bus1.out_valid_o && !bus1.stall_i[0]) begin
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("FAIL single_extra: got %h required none", bus1.out_data_o); end
        else begin exp_d = sb.pop_front(); if (bus1.out_data_o !== exp_d) begin miscompares++; $display("FAIL single_data: got %h required %h", bus1.out_data_o, exp_d); end end
      end
      @(posedge clk); #1;
      if (c == 0) begin
        vectors++; if (bus1.out_valid_o !== 1'b1 || bus1.out_data_o !== 32'h60) begin miscompares++; $display("FAIL single_latency: got %b/%h required 1/60", bus1.out_valid_o, bus1.out_data_o); end
      end
      vectors++; if (bus1.bubble_cnt_o !== 16'h0) begin miscompares++; $display("FAIL single_bubble_cnt: got %h required 0", bus1.bubble_cnt_o); end
    end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL single_lost: got %0d left required 0", sb.size()); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_reset_midstream();
    test_saturation();
    test_single_stage();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
